// File: rtl/nco_pkg.sv
// Shared types and default sizing for the NCO address generator.
// FSM state encoding plus default widths and wave-table read latency.
package nco_pkg;

    localparam int NCO_PHASE_W = 32;
    localparam int NCO_ADDR_W  = 16;
    localparam int NCO_DATA_W  = 16;
    localparam int NCO_RD_LAT  = 1;
    // Wide enough for the largest supported read latency (4).
    localparam int NCO_CNT_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } nco_state_e;

endpackage

// File: rtl/nco_amp_scale.sv
// Amplitude scaler: o_sample = (i_data * {0,i_amp}) >>> 8, truncated to DATA_W.
// Combinational, no latency; no flow control of its own (the capture edge decides).
// A full-scale amp of 0xFF is 255/256, deliberately just short of unity.
module nco_amp_scale #(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] i_data,
    input  logic [7:0]        i_amp,
    output logic [DATA_W-1:0] o_sample
);

    logic signed [DATA_W+8:0] prod;

    assign prod     = $signed(i_data) * $signed({1'b0, i_amp});
    assign o_sample = DATA_W'(prod >>> 8);

endmodule

// File: rtl/nco_addr_gen.sv
// NCO wave-table address generator: issues phase[MSBs] per tick, captures data RD_LAT+1 edges later.
// Latency: sample valid 1+RD_LAT edges after the issuing tick; optional NCO_AMP_SCALE_EN adds i_amp scaling.
// Backpressure: sample held until i_ready; ticks arriving while busy are dropped and flag o_overrun (sticky).
module nco_addr_gen
    import nco_pkg::*;
#(
    parameter int PHASE_W = NCO_PHASE_W,
    parameter int ADDR_W  = NCO_ADDR_W,
    parameter int DATA_W  = NCO_DATA_W,
    parameter int RD_LAT  = NCO_RD_LAT
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_en,
    input  logic               i_tick,
    input  logic [PHASE_W-1:0] i_fcw,
    input  logic               i_phase_rst,
    output logic [ADDR_W-1:0]  o_addr,
    input  logic [DATA_W-1:0]  i_data,
`ifdef NCO_AMP_SCALE_EN
    input  logic [7:0]         i_amp,
`endif
    output logic [DATA_W-1:0]  o_sample,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_overrun
);

    localparam logic [NCO_CNT_W-1:0] LAT_LAST = NCO_CNT_W'(RD_LAT);

    nco_state_e             state_q, state_d;
    logic [PHASE_W-1:0]     phase_q, phase_d, phase_base;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      sample_q, sample_d;
    logic                   valid_q, valid_d;
    logic                   overrun_q, overrun_d;
    logic [NCO_CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]      cap_dat;

`ifdef NCO_AMP_SCALE_EN
    nco_amp_scale #(
        .DATA_W   (DATA_W)
    ) u_amp_scale (
        .i_data   (i_data),
        .i_amp    (i_amp),
        .o_sample (cap_dat)
    );
`else
    assign cap_dat = i_data;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        sample_d   = sample_q;
        valid_d    = valid_q;
        overrun_d  = overrun_q;
        cnt_d      = cnt_q;
        // Phase clear wins over accumulate and applies in every state.
        phase_base = i_phase_rst ? '0 : phase_q;
        phase_d    = phase_base;

        case (state_q)
            ST_IDLE: begin
                if (i_en && i_tick) begin
                    addr_d  = phase_base[PHASE_W-1 -: ADDR_W];
                    phase_d = phase_base + i_fcw;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_tick) begin
                    overrun_d = 1'b1;
                end
                if (cnt_q == LAT_LAST) begin
                    sample_d = cap_dat;
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = ST_HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: begin
                // A tick on the handshake edge is still dropped: we are not yet idle.
                if (i_tick) begin
                    overrun_d = 1'b1;
                end
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            addr_q    <= '0;
            sample_q  <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            addr_q    <= addr_d;
            sample_q  <= sample_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_addr    = addr_q;
    assign o_sample  = sample_q;
    assign o_valid   = valid_q;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_nco_addr_gen.sv
// Self-checking bench for nco_addr_gen: directed literal cases plus randomized traffic
// compared every cycle against a transaction-level model (countdown to capture, busy flag).
module tb_nco_addr_gen;

    localparam int PHASE_W = 32;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int RD_LAT  = 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               i_en = 1'b0;
    logic               i_tick = 1'b0;
    logic [PHASE_W-1:0] i_fcw = '0;
    logic               i_phase_rst = 1'b0;
    logic [ADDR_W-1:0]  o_addr;
    logic [DATA_W-1:0]  i_data = '0;
    logic [DATA_W-1:0]  o_sample;
    logic               o_valid;
    logic               i_ready = 1'b1;
    logic               o_overrun;
`ifdef NCO_AMP_SCALE_EN
    logic [7:0]         i_amp = 8'hFF;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nco_addr_gen #(
        .PHASE_W     (PHASE_W),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .RD_LAT      (RD_LAT)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_en        (i_en),
        .i_tick      (i_tick),
        .i_fcw       (i_fcw),
        .i_phase_rst (i_phase_rst),
        .o_addr      (o_addr),
        .i_data      (i_data),
`ifdef NCO_AMP_SCALE_EN
        .i_amp       (i_amp),
`endif
        .o_sample    (o_sample),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_overrun   (o_overrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is "busy" from issue until its handshake;
    // edges_left counts down to the capture edge.
    logic [PHASE_W-1:0] m_phase   = '0;
    logic [ADDR_W-1:0]  m_addr    = '0;
    logic [DATA_W-1:0]  m_sample  = '0;
    logic               m_valid   = 1'b0;
    logic               m_overrun = 1'b0;
    logic               m_busy    = 1'b0;
    int                 m_left    = 0;

    function automatic logic [DATA_W-1:0] expected_sample(input logic [DATA_W-1:0] d);
`ifdef NCO_AMP_SCALE_EN
        longint p;
        p = longint'($signed(d)) * longint'(i_amp);
        p = p >>> 8;
        return p[DATA_W-1:0];
`else
        return d;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase = '0; m_addr = '0; m_sample = '0; m_valid = 1'b0;
            m_overrun = 1'b0; m_busy = 1'b0; m_left = 0;
        end else if (m_busy) begin
            if (i_tick) m_overrun = 1'b1;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_sample = expected_sample(i_data);
                    m_valid  = 1'b1;
                end
            end else if (i_ready) begin
                m_valid = 1'b0;
                m_busy  = 1'b0;
            end
            if (i_phase_rst) m_phase = '0;
        end else if (i_en && i_tick) begin
            logic [PHASE_W-1:0] base;
            base    = i_phase_rst ? '0 : m_phase;
            m_addr  = ADDR_W'(base >> (PHASE_W - ADDR_W));
            m_phase = base + i_fcw;
            m_busy  = 1'b1;
            m_left  = 1 + RD_LAT;
        end else if (i_phase_rst) begin
            m_phase = '0;
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(posedge clk) begin
        #2;
        if (rst_n) begin
            check("cyc_addr",    o_addr,    m_addr);
            check("cyc_valid",   o_valid,   m_valid);
            check("cyc_sample",  o_sample,  m_sample);
            check("cyc_overrun", o_overrun, m_overrun);
        end
    end

    task automatic issue(input logic [31:0] fcw, input logic prst,
                         output logic [ADDR_W-1:0] addr, output int lat);
        @(negedge clk);
        i_fcw = fcw; i_en = 1'b1; i_tick = 1'b1; i_phase_rst = prst;
        @(negedge clk);
        i_tick = 1'b0; i_phase_rst = 1'b0; i_fcw = $urandom;
        lat = 0;
        while (!o_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (!o_valid) check("issue_timeout", 1, 0);
        addr = o_addr;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] s;
    int                lat;

    initial begin
        i_data = 16'h1234;
        #12;
        check("rst_addr",    o_addr,    0);
        check("rst_valid",   o_valid,   0);
        check("rst_sample",  o_sample,  0);
        check("rst_overrun", o_overrun, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Tick every 8 cycles, fcw = 1<<16: addresses step by one.
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            issue(32'h0001_0000, 1'b0, a, lat);
            check("step_addr", a, k);
            check("step_lat", lat, 1 + RD_LAT);
`ifndef NCO_AMP_SCALE_EN
            check("step_sample", o_sample, 16'h1234);
`endif
            if (7 - lat > 0) repeat (7 - lat) @(negedge clk);
        end

        // Half-turn fcw wraps.
        pulse_reset();
        issue(32'h8000_0000, 1'b0, a, lat); check("wrap0", a, 16'h0000);
        issue(32'h8000_0000, 1'b0, a, lat); check("wrap1", a, 16'h8000);
        issue(32'h8000_0000, 1'b0, a, lat); check("wrap2", a, 16'h0000);

        // Phase clear coincident with an issuing tick.
        issue(32'h0002_0000, 1'b1, a, lat); check("prst_addr0", a, 0);
        issue(32'h0002_0000, 1'b0, a, lat); check("prst_addr1", a, 2);

        // Stalled downstream with a dropped tick in HOLD.
        pulse_reset();
        i_ready = 1'b0;
        issue(32'h0001_0000, 1'b0, a, lat);
        check("stall_addr0", a, 0);
        s = o_sample;
        i_data = 16'h5A5A;
        @(negedge clk); i_tick = 1'b1;
        @(negedge clk); i_tick = 1'b0;
        for (int k = 0; k < 10; k++) begin
            check("stall_sample", o_sample, s);
            check("stall_valid", o_valid, 1);
            @(negedge clk);
        end
        check("stall_overrun", o_overrun, 1);
        i_ready = 1'b1;
        @(negedge clk);
        issue(32'h0001_0000, 1'b0, a, lat);
        check("stall_next_addr", a, 1);
        check("stall_overrun_sticky", o_overrun, 1);

        // Asynchronous reset in the middle of WAIT.
        issue(32'h0001_0000, 1'b0, a, lat);
        check("pre_rst_addr", a, 2);
        @(negedge clk);
        i_fcw = 32'h0001_0000; i_tick = 1'b1; i_en = 1'b1;
        @(posedge clk);
        #3 i_tick = 1'b0;
        check("mid_wait_addr", o_addr, 3);
        rst_n = 1'b0;
        #1;
        check("async_addr", o_addr, 0);
        check("async_valid", o_valid, 0);
        check("async_overrun", o_overrun, 0);
        @(negedge clk); rst_n = 1'b1;
        issue(32'h0001_0000, 1'b0, a, lat);
        check("post_rst_addr", a, 0);

`ifdef NCO_AMP_SCALE_EN
        i_amp = 8'h80;
        i_data = 16'h4000;
        issue(32'h0001_0000, 1'b0, a, lat); check("amp_pos", o_sample, 16'h2000);
        i_data = 16'hC000;
        issue(32'h0001_0000, 1'b0, a, lat); check("amp_neg", o_sample, 16'hE000);
`endif

        // Randomized traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            rst_n       = ($urandom_range(0, 999) >= 3);
            i_en        = ($urandom_range(0, 9) != 0);
            i_tick      = ($urandom_range(0, 9) < 3);
            i_ready     = ($urandom_range(0, 9) < 6);
            i_phase_rst = ($urandom_range(0, 19) == 0);
            i_fcw       = ($urandom_range(0, 3) == 0) ? 32'h0001_0000 : $urandom;
            i_data      = DATA_W'($urandom);
`ifdef NCO_AMP_SCALE_EN
            i_amp       = 8'($urandom);
`endif
        end
        @(negedge clk);
        rst_n = 1'b1; i_tick = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/nco_addr_gen.md
NCO_ADDR_GEN -- requirements
Module: nco_addr_gen

Interface
- REQ-001 SHALL have parameter PHASE_W, default 32: phase accumulator width.
- REQ-002 SHALL have parameter ADDR_W, default 16: wave-table address width.
- REQ-003 SHALL have parameter DATA_W, default 16: signed two's-complement sample width.
- REQ-004 SHALL have parameter RD_LAT, default 1: wave-table read latency in cycles, range 1..4.
- REQ-005 SHALL have port i_clk, input, 1: single clock, rising edge.
- REQ-006 SHALL have port i_rst_n, input, 1: reset, asynchronous assert, active-low.
- REQ-007 SHALL have port i_en, input, 1: generator enable.
- REQ-008 SHALL have port i_tick, input, 1: one-cycle sample-rate strobe.
- REQ-009 SHALL have port i_fcw, input, PHASE_W: frequency control word.
- REQ-010 SHALL have port i_phase_rst, input, 1: synchronous phase clear.
- REQ-011 SHALL have port o_addr, output, ADDR_W: registered wave-table address, phase[PHASE_W-1 -: ADDR_W].
- REQ-012 SHALL have port i_data, input, DATA_W: wave-table read data.
- REQ-013 SHALL have port o_sample, output, DATA_W: captured sample.
- REQ-014 SHALL have port o_valid, output, 1: sample valid.
- REQ-015 SHALL have port i_ready, input, 1: downstream accept.
- REQ-016 SHALL have port o_overrun, output, 1: sticky dropped-tick flag.

Function
- REQ-017 SHALL implement FSM IDLE -> WAIT -> HOLD -> IDLE.
- REQ-018 IDLE with i_en=1 and i_tick=1 at edge N SHALL load o_addr from the current phase, set phase to phase+i_fcw mod 2^PHASE_W, and enter WAIT.
- REQ-019 WAIT SHALL count RD_LAT cycles, then at edge N+1+RD_LAT load o_sample from i_data, set o_valid=1, and enter HOLD.
- REQ-020 HOLD SHALL keep o_sample and o_valid stable until i_ready=1, then clear o_valid at that edge and enter IDLE.
- REQ-021 The first issued address after reset SHALL be 0.
- REQ-022 i_tick outside IDLE, or in IDLE on the same edge a HOLD handshake completes, SHALL be dropped and set o_overrun=1; o_overrun clears only on reset.
- REQ-023 i_phase_rst=1 SHALL force phase to 0 and override the accumulate; with a simultaneous issuing tick, the issued address SHALL be 0 and phase SHALL become i_fcw.
- REQ-024 i_en=0 SHALL block new issues only; an in-flight transaction SHALL complete normally and phase SHALL be held.
- REQ-025 i_fcw SHALL be sampled only at the issue edge.
- REQ-026 o_addr SHALL hold its value between issues.

Reset
- REQ-027 i_rst_n=0 SHALL asynchronously force state=IDLE, phase=0, o_addr=0, o_sample=0, o_valid=0, o_overrun=0, and the latency counter to 0, including mid-WAIT or mid-HOLD.
- REQ-028 After reset release, the first issue SHALL occur no earlier than the first i_tick sampled on a rising edge.

Configuration
- REQ-029 With NCO_AMP_SCALE_EN defined, the module SHALL add input i_amp[7:0], and the capture SHALL load o_sample = (i_data * {1'b0,i_amp}) >>> 8, signed, truncated to DATA_W; i_amp=0xFF SHALL NOT equal unity.
- REQ-030 Without NCO_AMP_SCALE_EN, i_amp SHALL be absent and o_sample SHALL equal i_data unmodified.

Structure
- REQ-031 Package nco_pkg SHALL hold the FSM state enum and the default PHASE_W, ADDR_W, DATA_W, and RD_LAT constants.
- REQ-032 Sub-module nco_amp_scale SHALL contain the multiplier and SHALL be instantiated only under NCO_AMP_SCALE_EN.

Verification
- REQ-033 fcw=0x00010000, i_ready=1, tick every 8 cycles -> o_addr 0,1,2,3; each o_valid exactly 1+RD_LAT edges after its tick edge.
- REQ-034 fcw=0x80000000 -> o_addr 0x0000, 0x8000, 0x0000 (wrap).
- REQ-035 i_ready=0 for 10 cycles with a tick in HOLD -> o_sample stable, o_overrun=1, next address not advanced by the dropped tick.
- REQ-036 i_rst_n pulsed low mid-WAIT -> o_valid=0, o_addr=0 immediately, without waiting for a clock edge; next issued address 0.
- REQ-037 i_phase_rst and i_tick on the same edge, fcw=0x00020000 -> o_addr 0, then 2 on the next tick.
- REQ-038 NCO_AMP_SCALE_EN defined, i_amp=0x80, i_data=0x4000 -> o_sample=0x2000; i_data=0xC000 -> o_sample=0xE000.
